// File: rtl/alu_uart_pkg.sv
// Shared definitions for the UART command processor: command opcodes, ALU
// function codes, FSM state encodings and the combinational ALU.
package alu_uart_pkg;

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_MUL  = 4'd2,
        ALU_DIV  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_NAND = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_XOR  = 4'd8,
        ALU_XNOR = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_GT   = 4'd11,
        ALU_LT   = 4'd12,
        ALU_SHR  = 4'd13,
        ALU_SHL  = 4'd14,
        ALU_ZERO = 4'd15
    } alu_fun_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_RD_ADDR,
        ST_ALU_A,
        ST_ALU_B,
        ST_ALU_FUN
    } cmd_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    // All results wrap to 8 bits; divide by zero yields zero.
    function automatic logic [7:0] alu_compute(input logic [7:0] a,
                                               input logic [7:0] b,
                                               input logic [3:0] fun);
        logic [7:0] r;
        case (alu_fun_t'(fun))
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_MUL:  r = a * b;
            ALU_DIV:  r = (b == 8'd0) ? 8'h00 : a / b;
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            ALU_XOR:  r = a ^ b;
            ALU_XNOR: r = ~(a ^ b);
            ALU_EQ:   r = (a == b) ? 8'd1 : 8'd0;
            ALU_GT:   r = (a > b) ? 8'd2 : 8'd0;
            ALU_LT:   r = (a < b) ? 8'd3 : 8'd0;
            ALU_SHR:  r = a >> 1;
            ALU_SHL:  r = a << 1;
            default:  r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_bit_rx.sv
// UART receiver: synchronizes the serial line, times bits from the start edge,
// and checks even parity and the stop bit of each 11-bit frame.
module uart_bit_rx
    import alu_uart_pkg::*;
#(
    parameter int PRESCALE = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       serial,
    output logic [7:0] data,
    output logic       valid,
    output logic       error
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(PRESCALE / 2 - 1);

    logic [1:0]       sync_q;
    logic             line_s;
    logic             line_prev;
    rx_state_t        state;
    rx_state_t        state_next;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             parity;
    logic             tick;
    logic             half_tick;

    assign line_s    = sync_q[1];
    assign tick      = (cnt == FULL_LAST);
    assign half_tick = (cnt == HALF_LAST);
    assign data      = shift;

    // Start needs a real high-to-low edge, so a line held low out of reset
    // or after a bad stop bit never launches a frame.
    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:   if (line_prev && !line_s) state_next = RX_START;
            RX_START:  if (half_tick) state_next = line_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tick && bit_idx == 3'd7) state_next = RX_PARITY;
            RX_PARITY: if (tick) state_next = RX_STOP;
            RX_STOP:   if (tick) state_next = RX_IDLE;
            default:   state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            line_prev <= 1'b0;
            state     <= RX_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            parity    <= 1'b0;
            valid     <= 1'b0;
            error     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], serial};
            line_prev <= line_s;
            state     <= state_next;
            valid     <= 1'b0;
            error     <= 1'b0;
            cnt       <= (state_next != state || tick) ? '0 : cnt + 1'b1;
            case (state)
                RX_IDLE: bit_idx <= '0;
                RX_DATA: begin
                    if (tick) begin
                        shift   <= {line_s, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end
                RX_PARITY: if (tick) parity <= line_s;
                RX_STOP: begin
                    if (tick) begin
                        if (line_s && (parity == ^shift)) valid <= 1'b1;
                        else error <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_uart_sys.sv
// UART command processor top: decodes write/read/ALU command packets against a
// 16x8 register file and serializes responses through a small TX queue.
module alu_uart_sys
    import alu_uart_pkg::*;
#(
    parameter int PRESCALE   = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic ref_clk,
    input  logic rst,
    input  logic rx_in,
    output logic tx_out
);

    localparam int CNT_W = $clog2(PRESCALE);
    localparam int PW    = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(PRESCALE - 1);

    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_error;

    cmd_state_t       state;
    cmd_state_t       state_next;
    logic [7:0]       regs [16];
    logic [3:0]       addr;
    logic             addr_we;
    logic             reg_we;
    logic [3:0]       reg_waddr;
    logic             push;
    logic [7:0]       push_data;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push_ok;
    logic             pop;

    logic             tx_busy;
    logic [CNT_W-1:0] tx_cnt;
    logic [3:0]       tx_bit;
    logic [9:0]       tx_shift;
    logic             tx_line;
    logic             tx_tick;
    logic             tx_ready;

    uart_bit_rx #(.PRESCALE(PRESCALE)) u_rx (
        .clk    (ref_clk),
        .rst_n  (rst),
        .serial (rx_in),
        .data   (rx_data),
        .valid  (rx_valid),
        .error  (rx_error)
    );

    // A framing or parity error always resynchronizes the packet parser.
    always_comb begin
        state_next = state;
        addr_we    = 1'b0;
        reg_we     = 1'b0;
        reg_waddr  = 4'd0;
        push       = 1'b0;
        push_data  = 8'h00;
        if (rx_error) begin
            state_next = ST_IDLE;
        end else if (rx_valid) begin
            case (state)
                ST_IDLE: begin
                    case (rx_data)
                        CMD_WR:      state_next = ST_WR_ADDR;
                        CMD_RD:      state_next = ST_RD_ADDR;
                        CMD_ALU_OP:  state_next = ST_ALU_A;
                        CMD_ALU_NOP: state_next = ST_ALU_FUN;
                        default:     state_next = ST_IDLE;
                    endcase
                end
                ST_WR_ADDR: begin
                    addr_we    = 1'b1;
                    state_next = ST_WR_DATA;
                end
                ST_WR_DATA: begin
                    reg_we     = 1'b1;
                    reg_waddr  = addr;
                    state_next = ST_IDLE;
                end
                ST_RD_ADDR: begin
                    push       = 1'b1;
                    push_data  = regs[rx_data[3:0]];
                    state_next = ST_IDLE;
                end
                ST_ALU_A: begin
                    reg_we     = 1'b1;
                    reg_waddr  = 4'd0;
                    state_next = ST_ALU_B;
                end
                ST_ALU_B: begin
                    reg_we     = 1'b1;
                    reg_waddr  = 4'd1;
                    state_next = ST_ALU_FUN;
                end
                ST_ALU_FUN: begin
                    push       = 1'b1;
                    push_data  = alu_compute(regs[0], regs[1], rx_data[3:0]);
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            addr  <= '0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (addr_we) addr <= rx_data[3:0];
            if (reg_we) regs[reg_waddr] <= rx_data;
        end
    end

    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_ok    = push && !fifo_full;
    assign tx_tick    = (tx_cnt == FULL_LAST);
    // Popping in the last stop-bit cycle keeps queued frames back-to-back.
    assign tx_ready   = !tx_busy || (tx_tick && tx_bit == 4'd10);
    assign pop        = !fifo_empty && tx_ready;

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge ref_clk or negedge rst) begin
        if (!rst) begin
            tx_busy  <= 1'b0;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_line  <= 1'b1;
        end else if (pop) begin
            tx_shift <= {1'b1, ^fifo_mem[rd_ptr], fifo_mem[rd_ptr]};
            tx_line  <= 1'b0;
            tx_busy  <= 1'b1;
            tx_cnt   <= '0;
            tx_bit   <= '0;
        end else if (tx_busy) begin
            if (tx_tick) begin
                tx_cnt <= '0;
                if (tx_bit == 4'd10) begin
                    tx_busy <= 1'b0;
                    tx_line <= 1'b1;
                end else begin
                    tx_bit   <= tx_bit + 1'b1;
                    tx_line  <= tx_shift[0];
                    tx_shift <= {1'b1, tx_shift[9:1]};
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    assign tx_out = tx_line;

endmodule

// File: tb/tb_alu_uart_sys.sv
// Self-checking bench: drives command frames on rx_in, decodes tx_out frames
// and compares them against a command-level model of the register file and ALU.
module tb_alu_uart_sys;

    localparam int PRESCALE   = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int HALF       = PRESCALE / 2;
    localparam int FRAME      = 11 * PRESCALE;

    logic ref_clk = 1'b0;
    logic rst     = 1'b1;
    logic rx_in   = 1'b1;
    logic tx_out;

    int n_checks    = 0;
    int n_fail      = 0;
    int frames_seen = 0;
    int exp_total   = 0;

    logic [7:0]  exp_q[$];
    logic [7:0]  model_regs [16];
    logic [10:0] last_frame = '0;
    bit          mon_busy   = 1'b0;

    alu_uart_sys #(.PRESCALE(PRESCALE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .ref_clk (ref_clk),
        .rst     (rst),
        .rx_in   (rx_in),
        .tx_out  (tx_out)
    );

    always #5 ref_clk = ~ref_clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] alu_model(input int a, input int b, input int f);
        int r;
        case (f)
            0:  r = a + b;
            1:  r = a - b + 256;
            2:  r = a * b;
            3:  r = (b == 0) ? 0 : a / b;
            4:  r = a & b;
            5:  r = a | b;
            6:  r = 255 - (a & b);
            7:  r = 255 - (a | b);
            8:  r = a ^ b;
            9:  r = 255 - (a ^ b);
            10: r = (a == b) ? 1 : 0;
            11: r = (a > b) ? 2 : 0;
            12: r = (a < b) ? 3 : 0;
            13: r = a / 2;
            14: r = a * 2;
            default: r = 0;
        endcase
        return 8'(r % 256);
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input bit bad_parity = 1'b0,
                                 input bit bad_stop = 1'b0);
        logic [10:0] f;
        f = {~bad_stop, (^b) ^ bad_parity, b, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_in = f[i];
            repeat (PRESCALE) @(negedge ref_clk);
        end
        rx_in = 1'b1;
        repeat (PRESCALE) @(negedge ref_clk);
    endtask

    task automatic send_write(input logic [7:0] a, input logic [7:0] d);
        applyStimulus(8'hAA);
        applyStimulus(a);
        applyStimulus(d);
        model_regs[a[3:0]] = d;
    endtask

    task automatic send_read(input logic [7:0] a);
        exp_q.push_back(model_regs[a[3:0]]);
        exp_total++;
        applyStimulus(8'hBB);
        applyStimulus(a);
    endtask

    task automatic send_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
        model_regs[0] = a;
        model_regs[1] = b;
        exp_q.push_back(alu_model(a, b, f));
        exp_total++;
        applyStimulus(8'hCC);
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus({4'h0, f});
    endtask

    task automatic send_fun(input logic [3:0] f);
        exp_q.push_back(alu_model(model_regs[0], model_regs[1], f));
        exp_total++;
        applyStimulus(8'hDD);
        applyStimulus({4'h0, f});
    endtask

    task automatic wait_drain();
        int budget;
        budget = 3 * FRAME;
        while ((exp_q.size() != 0 || mon_busy) && budget > 0) begin
            @(negedge ref_clk);
            budget--;
        end
        checkOutput("drain_pending", exp_q.size(), 0);
    endtask

    // Frame decoder and comparator for everything the DUT transmits.
    initial begin : tx_monitor
        logic [10:0] f;
        forever begin
            @(negedge ref_clk);
            if (rst && tx_out == 1'b0) begin
                mon_busy = 1'b1;
                repeat (HALF) @(negedge ref_clk);
                f[0] = tx_out;
                for (int i = 1; i < 11; i++) begin
                    repeat (PRESCALE) @(negedge ref_clk);
                    f[i] = tx_out;
                end
                frames_seen++;
                last_frame = f;
                checkOutput("tx_start_bit", f[0], 0);
                checkOutput("tx_stop_bit", f[10], 1);
                checkOutput("tx_parity", f[9], ^f[8:1]);
                checkOutput("tx_frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) checkOutput("tx_data", f[8:1], exp_q.pop_front());
                mon_busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        repeat (90000) @(posedge ref_clk);
        n_fail++;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;

        #1 rst = 1'b0;
        rx_in = 1'b0;
        repeat (8) @(negedge ref_clk);
        checkOutput("reset_tx_out", tx_out, 1);
        @(negedge ref_clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        for (int i = 0; i < 24; i++) begin
            repeat (HALF) @(negedge ref_clk);
            checkOutput("post_reset_idle", tx_out, 1);
        end
        checkOutput("post_reset_frames", frames_seen, 0);

        send_write(8'h08, 8'hDD);
        repeat (2 * FRAME) @(negedge ref_clk);
        checkOutput("write_no_tx", frames_seen, 0);

        send_read(8'h08);
        wait_drain();
        checkOutput("read_reg8_frame", last_frame, {1'b1, 1'b0, 8'hDD, 1'b0});

        send_alu(8'h08, 8'h02, 4'h1);
        wait_drain();
        checkOutput("alu_sub_literal", last_frame[8:1], 8'h06);
        checkOutput("alu_sub_parity", last_frame[9], 0);

        send_fun(4'hD);
        wait_drain();
        checkOutput("alu_shr_literal", last_frame[8:1], 8'h04);

        // Bad parity on the address byte must drop it and return to IDLE.
        applyStimulus(8'hAA);
        applyStimulus(8'h03, 1'b1, 1'b0);
        send_read(8'h03);
        wait_drain();
        checkOutput("parity_resync_literal", last_frame[8:1], 8'h00);

        applyStimulus(8'hAA);
        applyStimulus(8'h05, 1'b0, 1'b1);
        send_read(8'h08);
        wait_drain();
        checkOutput("stop_resync_literal", last_frame[8:1], 8'hDD);

        // A short low pulse between bytes must be rejected as a glitch.
        exp_q.push_back(model_regs[8]);
        exp_total++;
        applyStimulus(8'hBB);
        rx_in = 1'b0;
        repeat (3) @(negedge ref_clk);
        rx_in = 1'b1;
        repeat (2 * PRESCALE) @(negedge ref_clk);
        applyStimulus(8'h08);
        wait_drain();
        checkOutput("glitch_read_literal", last_frame[8:1], 8'hDD);

        send_alu(8'hC8, 8'h3C, 4'h0);
        wait_drain();
        checkOutput("alu_add_wrap_literal", last_frame[8:1], 8'h04);
        for (int f = 1; f < 16; f++) begin
            send_fun(4'(f));
            wait_drain();
        end

        send_alu(8'h05, 8'h00, 4'h3);
        wait_drain();
        checkOutput("alu_div0_literal", last_frame[8:1], 8'h00);
        send_fun(4'hA);
        wait_drain();
        send_fun(4'hB);
        wait_drain();
        checkOutput("alu_gt_literal", last_frame[8:1], 8'h02);
        send_fun(4'hC);
        wait_drain();

        send_alu(8'h7F, 8'h7F, 4'hA);
        wait_drain();
        checkOutput("alu_eq_literal", last_frame[8:1], 8'h01);
        send_fun(4'h1);
        wait_drain();

        send_alu(8'h10, 8'hF0, 4'hC);
        wait_drain();
        checkOutput("alu_lt_literal", last_frame[8:1], 8'h03);
        send_fun(4'h2);
        wait_drain();
        send_fun(4'hB);
        wait_drain();

        send_write(8'h1F, 8'h5A);
        applyStimulus(8'h12);
        send_read(8'h0F);
        wait_drain();
        checkOutput("addr_mask_literal", last_frame[8:1], 8'h5A);
        send_read(8'h00);
        wait_drain();

        checkOutput("frame_count", frames_seen, exp_total);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
